// File: rtl/wavelet_core_if.sv
// ---------------------------------------------------------------------------
// wavelet_core_if
// Bundle between the wavelet controller and the filter core.
//
// Handshake rules:
//   * tap_we is a single-cycle write strobe. tap_addr and tap_data are valid
//     while tap_we is high.
//   * A sample transfers on a rising edge where smp_valid && smp_ready.
//     Once smp_valid rises, it and smp_data stay put until that edge.
//     smp_ready may depend on smp_valid.
//   * res_valid is a single-cycle strobe qualifying res_data. It has no
//     back-pressure.
//
// Modports:
//   master - controller side: drives tap_*, smp_valid and smp_data.
//   slave  - core side: drives smp_ready, res_valid and res_data.
// ---------------------------------------------------------------------------
interface wavelet_core_if #(
  parameter int DW = 8
);
  logic          tap_we;
  logic [4:0]    tap_addr;
  logic [DW-1:0] tap_data;
  logic          smp_valid;
  logic [DW-1:0] smp_data;
  logic          smp_ready;
  logic          res_valid;
  logic [15:0]   res_data;

  modport master (
    output tap_we, tap_addr, tap_data, smp_valid, smp_data,
    input  smp_ready, res_valid, res_data
  );

  modport slave (
    input  tap_we, tap_addr, tap_data, smp_valid, smp_data,
    output smp_ready, res_valid, res_data
  );
endinterface

// File: rtl/wavelet_ctrl.sv
// ---------------------------------------------------------------------------
// wavelet_ctrl
// Host-to-core bridge for a wavelet filter.
//
// The host toggles la_in[31] to issue a command. The toggle bit is taken
// through a two-flop synchroniser. The controller writes taps, pushes
// samples, or flushes the core with zeros. It reports progress on la_out
// and toggles an ack bit when each command completes.
//
// Ports:
//   wb_clk_i  clock (rising edge)
//   wb_rst_n  asynchronous active-low reset
//   active    block enable; when low the controller aborts to IDLE
//   la_in     command word: [31] strobe, [30:29] opcode, [28:24] tap index,
//             [DW-1:0] data
//   la_out    status word: [31] ack, [30] busy, [29] timeout, [28] error,
//             [27:16] sample count, [15:0] last result
//   state_o   current FSM state, for debug
//   core      filter-core bundle (master side)
// ---------------------------------------------------------------------------
module wavelet_ctrl #(
  parameter int N_TAPS  = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_n,
  input  logic           active,
  input  logic [31:0]    la_in,
  output logic [31:0]    la_out,
  output logic [2:0]     state_o,
  wavelet_core_if.master core
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [4:0]    NT      = 5'(N_TAPS);
  localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TAP_WR   = 3'd1,
    S_SMP_SEND = 3'd2,
    S_RES_WAIT = 3'd3,
    S_FLUSH    = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Synchroniser and edge detector for the command strobe.
  logic       sync1_q, sync2_q, prev_q;
  logic [1:0] prime_q;
  logic       cmd_evt;

  // Datapath registers.
  logic          ack_q, ack_d, ack_pend_q, ack_pend_d;
  logic          to_q, to_d, err_q, err_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [15:0]   res_q, res_d;
  logic [4:0]    tap_addr_q, tap_addr_d;
  logic [DW-1:0] tap_data_q, tap_data_d, smp_q, smp_d;
  logic          flush_q, flush_d;
  logic [4:0]    flush_left_q, flush_left_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [1:0] op;
  logic [4:0] idx;
  logic       accept, err_busy, tmo_hit, ack_toggle, busy;

  // Bits between the data field and the tap index carry no meaning.
  if (DW < 24) begin : g_unused
    logic unused_la_bits;
    assign unused_la_bits = ^la_in[23:DW];
  end

  assign op       = la_in[30:29];
  assign idx      = la_in[28:24];
  assign accept   = cmd_evt && active && (state_q == S_IDLE);
  assign err_busy = cmd_evt && active && (state_q != S_IDLE);
  assign tmo_hit  = (timer_q == TMO_END);

  // Edge detection is held off until prev_q has loaded the synchronised
  // level. This stops the strobe level present at reset release from being
  // read as a command.
  assign cmd_evt = (prime_q == 2'd3) && (sync2_q != prev_q);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      prime_q <= 2'd0;
    end else begin
      sync1_q <= la_in[31];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
    end
  end

  // FSM: state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    if (!active) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (op)
              2'b01:   if (idx < NT) state_d = S_TAP_WR;
              2'b10:   state_d = S_SMP_SEND;
              2'b11:   state_d = S_FLUSH;
              default: state_d = S_IDLE;
            endcase
          end
        end
        S_TAP_WR:   state_d = S_IDLE;
        S_SMP_SEND: if (core.smp_ready) state_d = S_RES_WAIT;
        S_RES_WAIT: if (core.res_valid || tmo_hit) state_d = flush_q ? S_FLUSH : S_IDLE;
        S_FLUSH:    state_d = (flush_left_q == 5'd0) ? S_IDLE : S_SMP_SEND;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs. The strobes are gated by active, so an abort drops them
  // at once.
  always_comb begin
    busy           = (state_q != S_IDLE);
    core.tap_we    = (state_q == S_TAP_WR) && active;
    core.tap_addr  = tap_addr_q;
    core.tap_data  = tap_data_q;
    core.smp_valid = (state_q == S_SMP_SEND) && active;
    core.smp_data  = smp_q;
    state_o        = state_q;
    la_out         = {ack_q, busy, to_q, err_q, cnt_q, res_q};
  end

  // Datapath next state.
  always_comb begin
    ack_pend_d   = 1'b0;
    to_d         = to_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    tap_addr_d   = tap_addr_q;
    tap_data_d   = tap_data_q;
    smp_d        = smp_q;
    flush_d      = flush_q;
    flush_left_d = flush_left_q;
    timer_d      = timer_q;
    ack_toggle   = 1'b0;
    if (!active) begin
      flush_d = 1'b0;
      timer_d = '0;
    end else begin
      // NOP and a bad tap index finish in IDLE. Their ack is delayed by one
      // cycle so it lands at the same point as a real tap write.
      if (ack_pend_q) ack_toggle = 1'b1;
      if (err_busy)   err_d      = 1'b1;
      if (accept) begin
        case (op)
          2'b00: begin
            ack_pend_d = 1'b1;
            if (la_in[0]) begin
              to_d  = 1'b0;
              err_d = 1'b0;
            end
          end
          2'b01: begin
            if (idx < NT) begin
              tap_addr_d = idx;
              tap_data_d = la_in[DW-1:0];
            end else begin
              err_d      = 1'b1;
              ack_pend_d = 1'b1;
            end
          end
          2'b10: smp_d = la_in[DW-1:0];
          default: begin
            smp_d        = '0;
            flush_d      = 1'b1;
            flush_left_d = NT;
          end
        endcase
      end
      case (state_q)
        S_TAP_WR: ack_toggle = 1'b1;
        S_SMP_SEND: begin
          if (core.smp_ready) begin
            timer_d = '0;
            if (flush_q) flush_left_d = flush_left_q - 5'd1;
            else         cnt_d        = cnt_q + 12'd1;
          end
        end
        S_RES_WAIT: begin
          timer_d = timer_q + 1'b1;
          if (core.res_valid) begin
            res_d = core.res_data;
            if (!flush_q) ack_toggle = 1'b1;
          end else if (tmo_hit) begin
            to_d = 1'b1;
            if (!flush_q) ack_toggle = 1'b1;
          end
        end
        S_FLUSH: begin
          if (flush_left_q == 5'd0) begin
            ack_toggle = 1'b1;
            flush_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end
    ack_d = ack_q ^ ack_toggle;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q        <= 1'b0;
      ack_pend_q   <= 1'b0;
      to_q         <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      res_q        <= '0;
      tap_addr_q   <= '0;
      tap_data_q   <= '0;
      smp_q        <= '0;
      flush_q      <= 1'b0;
      flush_left_q <= '0;
      timer_q      <= '0;
    end else begin
      ack_q        <= ack_d;
      ack_pend_q   <= ack_pend_d;
      to_q         <= to_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      tap_addr_q   <= tap_addr_d;
      tap_data_q   <= tap_data_d;
      smp_q        <= smp_d;
      flush_q      <= flush_d;
      flush_left_q <= flush_left_d;
      timer_q      <= timer_d;
    end
  end

endmodule

// File: tb/tb_wavelet_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wavelet_ctrl
// Self-checking bench for wavelet_ctrl.
//
// A behavioural model tracks the status word from the command semantics
// (ack parity, stickies, sample count, last result). It also keeps queues
// of the tap writes and sample transfers the core should see. A core
// responder answers samples after a programmable delay.
// ---------------------------------------------------------------------------
module tb_wavelet_ctrl;
  localparam int N_TAPS  = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 255;

  logic        clk;
  logic        wb_rst_n;
  logic        active;
  logic [31:0] la_in;
  logic [31:0] la_out;
  logic [2:0]  state_o;

  wavelet_core_if #(.DW(DW)) cif();

  wavelet_ctrl #(.N_TAPS(N_TAPS), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (wb_rst_n),
    .active   (active),
    .la_in    (la_in),
    .la_out   (la_out),
    .state_o  (state_o),
    .core     (cif)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_tap   = 0;
  int n_hs    = 0;
  int hs_cyc  = 0;
  int ack_cyc = 0;
  int unstable = 0;

  logic [12:0]   exp_tap_q[$];
  logic [DW-1:0] exp_smp_q[$];

  logic        m_ack, m_to, m_err;
  logic [11:0] m_cnt;
  logic [15:0] m_res;

  // Responder knobs, set by the driver before each command.
  int            ready_dly = 0;
  int            resp_dly  = 0;
  bit            resp_en   = 1'b1;
  logic [15:0]   res_val   = 16'h0;
  logic [DW-1:0] cur_smp   = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {m_ack, 1'b0, m_to, m_err, m_cnt, m_res};
  endfunction

  task automatic check_status(input string tag);
    check_eq(tag, la_out, model_status());
    check_eq("pending_xfers", 32'(exp_tap_q.size() + exp_smp_q.size()), 32'd0);
    check_eq("smp_stable", 32'(unstable), 32'd0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (wb_rst_n && cif.tap_we === 1'b1) begin
      n_tap++;
      check_eq("tap_expected", 32'(exp_tap_q.size() > 0), 32'd1);
      if (exp_tap_q.size() > 0)
        check_eq("tap_write", 32'({cif.tap_addr, cif.tap_data}), 32'(exp_tap_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (wb_rst_n && cif.smp_valid === 1'b1 && cif.smp_ready === 1'b1) begin
      n_hs++;
      hs_cyc = cyc;
      check_eq("smp_expected", 32'(exp_smp_q.size() > 0), 32'd1);
      if (exp_smp_q.size() > 0)
        check_eq("smp_data", 32'(cif.smp_data), 32'(exp_smp_q.pop_front()));
    end
  end

  // ---------------- core responder ----------------
  initial begin
    bit aborted;
    cif.smp_ready = 1'b0;
    cif.res_valid = 1'b0;
    cif.res_data  = 16'h0;
    forever begin
      @(negedge clk);
      if (cif.smp_valid === 1'b1) begin
        aborted = 1'b0;
        for (int k = 0; k < ready_dly; k++) begin
          if (cif.smp_data !== cur_smp) unstable++;
          @(negedge clk);
          if (cif.smp_valid !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          cif.smp_ready = 1'b1;
          @(negedge clk);
          cif.smp_ready = 1'b0;
          if (resp_en) begin
            for (int k = 0; k < resp_dly; k++) @(negedge clk);
            cif.res_valid = 1'b1;
            cif.res_data  = res_val;
            @(negedge clk);
            cif.res_valid = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input logic [1:0] op, input logic [4:0] idx, input logic [7:0] data);
    @(negedge clk);
    la_in = {~la_in[31], op, idx, 16'h0, data};
  endtask

  // Waits until the ack bit matches the model. Returns the number of falling
  // edges waited.
  task automatic wait_ack(input int budget, output int lat);
    bit seen = 1'b0;
    lat = budget;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (la_out[31] === m_ack) begin
        seen    = 1'b1;
        lat     = k + 1;
        ack_cyc = cyc;
        break;
      end
    end
    check_eq("ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic do_nop(input logic d0);
    int lat;
    if (d0) begin
      m_to  = 1'b0;
      m_err = 1'b0;
    end
    m_ack = ~m_ack;
    drive_cmd(2'b00, 5'd0, {7'd0, d0});
    wait_ack(20, lat);
    check_eq("nop_latency", 32'(lat), 32'd4);
    check_status("nop_status");
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [7:0] data);
    int lat;
    if (idx < N_TAPS) exp_tap_q.push_back({idx, data});
    else              m_err = 1'b1;
    m_ack = ~m_ack;
    drive_cmd(2'b01, idx, data);
    wait_ack(20, lat);
    check_eq("wr_latency", 32'(lat), 32'd4);
    check_status("wr_status");
  endtask

  task automatic do_push(input logic [7:0] data, input int rdy, input int rsp,
                         input bit en, input logic [15:0] rv);
    int lat;
    ready_dly = rdy;
    resp_dly  = rsp;
    resp_en   = en;
    res_val   = rv;
    cur_smp   = data;
    exp_smp_q.push_back(data);
    m_cnt = m_cnt + 12'd1;
    if (en) m_res = rv;
    else    m_to  = 1'b1;
    m_ack = ~m_ack;
    drive_cmd(2'b10, 5'd0, data);
    wait_ack(TIMEOUT + 100, lat);
    check_status("push_status");
  endtask

  task automatic do_flush(input int rdy, input int rsp, input logic [15:0] rv);
    int lat;
    ready_dly = rdy;
    resp_dly  = rsp;
    resp_en   = 1'b1;
    res_val   = rv;
    cur_smp   = '0;
    for (int i = 0; i < N_TAPS; i++) exp_smp_q.push_back('0);
    m_res = rv;
    m_ack = ~m_ack;
    drive_cmd(2'b11, 5'd0, 8'h0);
    wait_ack(600, lat);
    check_status("flush_status");
  endtask

  task automatic model_reset();
    m_ack = 1'b0;
    m_to  = 1'b0;
    m_err = 1'b0;
    m_cnt = '0;
    m_res = '0;
    exp_tap_q.delete();
    exp_smp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0, h0;
    int lat;
    logic [11:0] c0;

    wb_rst_n = 1'b0;
    active   = 1'b1;
    la_in    = 32'h8000_0000;   // strobe high while reset releases
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_status", la_out, 32'h0);
    check_eq("reset_strobes", 32'({cif.tap_we, cif.smp_valid}), 32'd0);
    wb_rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("release_no_cmd", la_out, 32'h0);

    // Single tap write.
    t0 = n_tap;
    do_write(5'd3, 8'h7F);
    check_eq("tap3_count", 32'(n_tap - t0), 32'd1);

    // Sample with delayed ready, then a result.
    do_push(8'h10, 5, 2, 1'b1, 16'h1234);
    check_eq("push_result", 32'(la_out[15:0]), 32'h1234);
    check_eq("push_count", 32'(la_out[27:16]), 32'd1);

    // Core never answers: timeout after TIMEOUT cycles in RES_WAIT. The
    // handshake is sampled half a cycle before RES_WAIT is entered, hence +1.
    do_push(8'h22, 1, 0, 1'b0, 16'h0);
    check_eq("tmo_cycles", 32'(ack_cyc - hs_cyc), 32'(TIMEOUT + 1));
    check_eq("tmo_idle", 32'(state_o), 32'd0);
    check_eq("tmo_result_kept", 32'(la_out[15:0]), 32'h1234);

    // Flush pushes N_TAPS zeros and leaves the count alone.
    h0 = n_hs;
    c0 = m_cnt;
    do_flush(1, 1, 16'h0F0F);
    check_eq("flush_hs", 32'(n_hs - h0), 32'(N_TAPS));
    check_eq("flush_count", 32'(la_out[27:16]), 32'(c0));

    // Strobe while busy in RES_WAIT is ignored and flags an error.
    do_nop(1'b1);
    ready_dly = 2; resp_dly = 30; resp_en = 1'b1; res_val = 16'hBEEF; cur_smp = 8'h33;
    exp_smp_q.push_back(8'h33);
    m_cnt = m_cnt + 12'd1;
    m_res = 16'hBEEF;
    m_ack = ~m_ack;
    drive_cmd(2'b10, 5'd0, 8'h33);
    repeat (12) @(negedge clk);
    check_eq("busy_mid_wait", 32'(la_out[30]), 32'd1);
    m_err = 1'b1;
    drive_cmd(2'b00, 5'd0, 8'h01);   // would clear stickies if it were accepted
    wait_ack(200, lat);
    check_status("busy_cmd_err");
    do_nop(1'b1);
    t0 = n_tap;
    do_write(5'd9, 8'hAA);
    check_eq("bad_idx_no_tap", 32'(n_tap - t0), 32'd0);
    do_nop(1'b1);

    // Abort through active; stickies, count and result must survive.
    do_write(5'd31, 8'h01);
    ready_dly = 30; resp_en = 1'b1; cur_smp = 8'h44;
    drive_cmd(2'b10, 5'd0, 8'h44);
    repeat (6) @(negedge clk);
    check_eq("abort_pre_valid", 32'(cif.smp_valid), 32'd1);
    active = 1'b0;
    @(negedge clk);
    check_eq("abort_valid", 32'(cif.smp_valid), 32'd0);
    check_status("abort_status");
    drive_cmd(2'b00, 5'd0, 8'h01);
    repeat (8) @(negedge clk);
    check_status("inactive_ignore");
    active = 1'b1;
    repeat (4) @(negedge clk);
    check_status("reactivate");

    // Reset in the middle of SMP_SEND.
    ready_dly = 40; resp_en = 1'b1; cur_smp = 8'h5A;
    drive_cmd(2'b10, 5'd0, 8'h5A);
    repeat (6) @(negedge clk);
    check_eq("rst_pre_valid", 32'(cif.smp_valid), 32'd1);
    #2 wb_rst_n = 1'b0;
    #1 check_eq("rst_async_valid", 32'(cif.smp_valid), 32'd0);
    check_eq("rst_mid_status", la_out, 32'h0);
    la_in = 32'h8000_0000;
    model_reset();
    repeat (2) @(negedge clk);
    wb_rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("rst_release", la_out, 32'h0);

    // Sample count wraps from 4095 to 0.
    for (int i = 0; i < 4095; i++) do_push(8'(i), 0, 0, 1'b1, 16'(i));
    check_eq("count_max", 32'(la_out[27:16]), 32'hFFF);
    do_push(8'hC3, 0, 0, 1'b1, 16'h5555);
    check_eq("count_wrap", 32'(la_out[27:16]), 32'd0);

    // Random command mix.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: do_nop(1'($urandom_range(0, 1)));
        1: do_write(5'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        2: do_push(8'($urandom_range(0, 255)), int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 8)), ($urandom_range(0, 7) != 0),
                   16'($urandom_range(0, 65535)));
        default: do_flush(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          16'($urandom_range(0, 65535)));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wavelet_ctrl.md
WAVELET_CTRL -- requirements
Module: wavelet_ctrl

Interface
REQ-001 Parameter N_TAPS, default 8: number of filter taps in the wavelet core; legal range 2..31.
REQ-002 Parameter DW, default 8: signed sample and tap width.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles to wait for a core result.
REQ-004 wb_clk_i  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-005 wb_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 active  in  1  block enable; low forces IDLE and ignores commands.
REQ-007 la_in  in  32  host command word: [31] strobe toggle, [30:29] opcode, [28:24] tap index, [DW-1:0] data.
REQ-008 la_out  out  32  status: [31] ack toggle, [30] busy, [29] timeout sticky, [28] error sticky, [27:16] sample count, [15:0] last result.
REQ-009 tap_we  out  1  one-cycle tap write strobe to core.
REQ-010 tap_addr  out  5  tap index for tap_we.
REQ-011 tap_data  out  DW  tap value for tap_we.
REQ-012 smp_valid  out  1  sample valid to core; held until smp_ready.
REQ-013 smp_data  out  DW  sample value; stable while smp_valid is high.
REQ-014 smp_ready  in  1  core accepts sample when smp_valid and smp_ready are both high.
REQ-015 res_valid  in  1  one-cycle result strobe from core.
REQ-016 res_data  in  16  signed result from core.

Function
REQ-017 la_in[31] SHALL pass through a 2-flop synchroniser; a command is any change of the synchronised bit versus its previous value; la_in[30:0] SHALL be captured in the cycle the change is detected.
REQ-018 Opcodes SHALL be: 00 NOP, 01 WRITE_TAP, 10 PUSH_SAMPLE, 11 FLUSH.
REQ-019 FSM states SHALL be IDLE, TAP_WR, SMP_SEND, RES_WAIT, FLUSH; busy = (state != IDLE).
REQ-020 IDLE + WRITE_TAP with index < N_TAPS -> TAP_WR; tap_we SHALL pulse for exactly one cycle the following cycle with the captured index and data; then -> IDLE and toggle ack.
REQ-021 WRITE_TAP with index >= N_TAPS SHALL set error sticky, issue no tap_we, toggle ack, and stay in IDLE.
REQ-022 IDLE + PUSH_SAMPLE -> SMP_SEND with smp_valid high; on handshake -> RES_WAIT, drop smp_valid the next cycle, and increment sample count (12-bit, wraps 4095->0).
REQ-023 In RES_WAIT, res_valid SHALL latch res_data into la_out[15:0], toggle ack, and return to IDLE.
REQ-024 RES_WAIT SHALL count cycles from entry; reaching TIMEOUT without res_valid SHALL set timeout sticky, toggle ack, and return to IDLE, leaving la_out[15:0] unchanged.
REQ-025 FLUSH SHALL push N_TAPS zero samples through SMP_SEND/RES_WAIT handshakes, not counted in sample count; ack toggles once, after the last result or timeout.
REQ-026 NOP SHALL toggle ack only; count and stickies unchanged.
REQ-027 A strobe change while busy SHALL be ignored and set error sticky; the in-flight command completes normally.
REQ-028 res_valid outside RES_WAIT SHALL be ignored.
REQ-029 Stickies (timeout, error) SHALL clear only on reset or a NOP issued with la_in[0]=1.
REQ-030 active low SHALL abort any operation within one cycle: -> IDLE, smp_valid and tap_we low, no ack toggle; count, stickies, and result retained.
REQ-031 Latency: ack toggles 3 cycles after the synchroniser input edge for WRITE_TAP and NOP.

Reset
REQ-032 wb_rst_n low SHALL immediately force state IDLE and all outputs and internal registers to 0, including the synchroniser and ack.
REQ-033 Reset deassertion SHALL NOT be interpreted as a command, whatever the level of la_in[31].

Verification
REQ-034 Write tap 3 = 0x7F -> single tap_we with addr 3 and data 0x7F; ack toggles; busy back to 0.
REQ-035 Push sample 0x10 with smp_ready delayed 5 cycles, then res_valid with 0x1234 -> smp_data held stable; la_out[15:0] = 0x1234; count = 1.
REQ-036 Push sample, core never responds, TIMEOUT = 255 -> la_out[29] set after 255 cycles in RES_WAIT; FSM in IDLE.
REQ-037 FLUSH with N_TAPS = 8 -> exactly 8 zero-sample handshakes, one ack toggle, count unchanged.
REQ-038 Strobe toggle during RES_WAIT, then write tap 9 -> error sticky set on both; no tap_we; NOP with la_in[0]=1 clears it.
REQ-039 wb_rst_n pulsed low mid-SMP_SEND -> smp_valid low asynchronously; all status bits 0 after release.
